// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-select codes,
// register-address width and the mult/div stall FSM state encoding.
package hazard_pkg;

   localparam int RA_W = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_XM = 2'b01;
   localparam logic [1:0] FWD_MW = 2'b10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Bundle of latch-chain register fields flowing into the hazard unit and the
// stall/flush/bypass controls flowing back to the latches.
// master: the pipeline latch chain; slave: the hazard unit.
interface pipeline_hazard_unit_if #(
   parameter int RA_W = hazard_pkg::RA_W
);
   logic [RA_W-1:0] fd_rs;
   logic [RA_W-1:0] fd_rt;
   logic            fd_uses_rt;
   logic [RA_W-1:0] dx_rs;
   logic [RA_W-1:0] dx_rt;
   logic [RA_W-1:0] dx_rd;
   logic            dx_is_load;
   logic            dx_is_md;
   logic [RA_W-1:0] xm_rd;
   logic [RA_W-1:0] mw_rd;
   logic            xm_we;
   logic            mw_we;
   logic            x_br_taken;

   logic            stall_pc;
   logic            stall_fd;
   logic            stall_dx;
   logic            bubble_dx;
   logic            bubble_xm;
   logic            flush_fd;
   logic [1:0]      fwd_a_sel;
   logic [1:0]      fwd_b_sel;
   logic            md_busy;
   logic [31:0]     perf_stall_cnt;
   logic [31:0]     perf_flush_cnt;

   modport master (
      output fd_rs, fd_rt, fd_uses_rt, dx_rs, dx_rt, dx_rd, dx_is_load, dx_is_md,
             xm_rd, mw_rd, xm_we, mw_we, x_br_taken,
      input  stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
             fwd_a_sel, fwd_b_sel, md_busy, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  fd_rs, fd_rt, fd_uses_rt, dx_rs, dx_rt, dx_rd, dx_is_load, dx_is_md,
             xm_rd, mw_rd, xm_we, mw_we, x_br_taken,
      output stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
             fwd_a_sel, fwd_b_sel, md_busy, perf_stall_cnt, perf_flush_cnt
   );

endinterface

// File: rtl/md_stall_fsm.sv
// Multi-cycle mult/div occupancy tracker. The start cycle plus MD_LATENCY-2
// BUSY cycles hold the pipeline; the DONE cycle releases it so the result
// moves into X/M, giving MD_LATENCY cycles of X occupancy in total.
module md_stall_fsm
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 32
) (
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   output logic md_busy,
   output logic md_hold
);

   localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

   md_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   // State and down-counter registers; async reset drops straight to IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= MD_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state, counter update and hold/busy decode.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      md_hold    = 1'b0;
      md_busy    = (state_reg != MD_IDLE);
      case (state_reg)
         MD_IDLE: begin
            if (start) begin
               md_hold    = 1'b1;
               cnt_next   = CNT_LOAD;
               // With the minimum latency there are no BUSY cycles at all.
               state_next = (MD_LATENCY > 2) ? MD_BUSY : MD_DONE;
            end
         end
         MD_BUSY: begin
            md_hold  = 1'b1;
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               state_next = MD_DONE;
            end
         end
         MD_DONE: begin
            state_next = MD_IDLE;
         end
         default: begin
            state_next = MD_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Backward-flowing pipeline control: operand bypass selects, load-use stall,
// taken-branch flush and mult/div stall. Optional performance counters are
// built only when HAZ_PERF_EN is defined; otherwise the count ports read 0.
module pipeline_hazard_unit
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   pipeline_hazard_unit_if.slave hz
);

   logic       md_start;
   logic       md_busy_raw;
   logic       md_hold_raw;
   logic       load_use;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       stall_pc;
   logic       stall_fd;
   logic       stall_dx;
   logic       bubble_dx;
   logic       bubble_xm;
   logic       flush_fd;

   // A mul/div squashed by a taken branch never starts.
   assign md_start = hz.dx_is_md && !hz.x_br_taken;

   md_stall_fsm #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_stall_fsm (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (md_start),
      .md_busy (md_busy_raw),
      .md_hold (md_hold_raw)
   );

   // Bypass selection: X/M is newer than M/W so it wins; r0 is never bypassed.
   always_comb begin
      fwd_a = FWD_RF;
      if (hz.xm_we && hz.xm_rd == hz.dx_rs && hz.dx_rs != '0) begin
         fwd_a = FWD_XM;
      end else if (hz.mw_we && hz.mw_rd == hz.dx_rs && hz.dx_rs != '0) begin
         fwd_a = FWD_MW;
      end
      fwd_b = FWD_RF;
      if (hz.xm_we && hz.xm_rd == hz.dx_rt && hz.dx_rt != '0) begin
         fwd_b = FWD_XM;
      end else if (hz.mw_we && hz.mw_rd == hz.dx_rt && hz.dx_rt != '0) begin
         fwd_b = FWD_MW;
      end
   end

   // Load-use detect; ignored while mult/div owns the pipe since F/D is frozen.
   assign load_use = hz.dx_is_load && (hz.dx_rd != '0) && !md_busy_raw &&
                     ((hz.dx_rd == hz.fd_rs) || (hz.fd_uses_rt && hz.dx_rd == hz.fd_rt));

   // Prioritised control: md stall > branch flush > load-use; gated by reset.
   always_comb begin
      stall_pc  = 1'b0;
      stall_fd  = 1'b0;
      stall_dx  = 1'b0;
      bubble_dx = 1'b0;
      bubble_xm = 1'b0;
      flush_fd  = 1'b0;
      if (!reset_n) begin
         stall_pc = 1'b0;
      end else if (md_hold_raw) begin
         stall_pc  = 1'b1;
         stall_fd  = 1'b1;
         stall_dx  = 1'b1;
         bubble_xm = 1'b1;
      end else if (hz.x_br_taken) begin
         flush_fd  = 1'b1;
         bubble_dx = 1'b1;
      end else if (load_use) begin
         stall_pc  = 1'b1;
         stall_fd  = 1'b1;
         bubble_dx = 1'b1;
      end
   end

   assign hz.stall_pc  = stall_pc;
   assign hz.stall_fd  = stall_fd;
   assign hz.stall_dx  = stall_dx;
   assign hz.bubble_dx = bubble_dx;
   assign hz.bubble_xm = bubble_xm;
   assign hz.flush_fd  = flush_fd;
   assign hz.fwd_a_sel = reset_n ? fwd_a : FWD_RF;
   assign hz.fwd_b_sel = reset_n ? fwd_b : FWD_RF;
   assign hz.md_busy   = reset_n && md_busy_raw;

`ifdef HAZ_PERF_EN
   logic [31:0] perf_stall_reg;
   logic [31:0] perf_flush_reg;

   // Saturating event counters for stall cycles and taken-branch flushes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_reg <= '0;
         perf_flush_reg <= '0;
      end else begin
         if (stall_pc && perf_stall_reg != 32'hFFFF_FFFF) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
         if (hz.x_br_taken && perf_flush_reg != 32'hFFFF_FFFF) begin
            perf_flush_reg <= perf_flush_reg + 32'd1;
         end
      end
   end

   assign hz.perf_stall_cnt = perf_stall_reg;
   assign hz.perf_flush_cnt = perf_flush_reg;
`else
   assign hz.perf_stall_cnt = 32'h0;
   assign hz.perf_flush_cnt = 32'h0;
`endif

endmodule
